apb_reg_slave: RTL and testbench

- APB responder (completer) peripheral that sits on one PSELx line of the AHB-to-APB bridge's APB side.
- Terminates bridge-initiated APB transfers into a small word-addressed register bank.
- Inserts a programmable number of wait states via PREADY; flags bad accesses via PSLVERR.
- Provides a realistic synthesizable slave in place of a pass-through APB model, so bridge wait-state and error paths get exercised.

---
 rtl/apb_reg_slave.sv | 197 +++++++++++++++++++
 tb/tb_apb_reg_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// -----------------------------------------------------------------------------
// apb_reg_slave
//
// APB completer that terminates transfers from the AHB-to-APB bridge into a
// small word-addressed register bank. It inserts a programmable number of wait
// states before PREADY and can flag bad accesses through PSLVERR.
//
// Register map (byte address, only PADDR[11:0] decoded, word aligned):
//   idx 0 .. NUM_REGS-2 : read/write, reset to RESET_VAL
//   idx NUM_REGS-1      : read-only count of completed good writes (wraps)
//
// Parameters:
//   NUM_REGS    - number of 32-bit registers, 2..1024
//   WAIT_STATES - extra ACCESS cycles before PREADY rises, 0..15
//   RESET_VAL   - reset value of every read/write register
//
// Optional feature macro: APB_REG_SLAVE_SLVERR_EN
//   defined   : PSLVERR=1 with PREADY on a bad access, bad reads return 0
//   undefined : PSLVERR tied low, bad writes dropped, bad reads return
//               32'hDEAD_BEEF
//
// Ports:
//   HCLK     in   APB clock
//   HRESET   in   synchronous reset, active high
//   PSEL     in   slave select
//   PENABLE  in   access phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address [31:0]
//   PWDATA   in   write data [31:0]
//   PRDATA   out  read data, valid while PREADY=1 on a read
//   PREADY   out  transfer completion (one cycle)
//   PSLVERR  out  error response, valid while PREADY=1
// -----------------------------------------------------------------------------
module apb_reg_slave #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

`ifdef APB_REG_SLAVE_SLVERR_EN
    localparam logic        SLVERR_EN   = 1'b1;
    localparam logic [31:0] BAD_RD_DATA = 32'h0000_0000;
`else
    localparam logic        SLVERR_EN   = 1'b0;
    localparam logic [31:0] BAD_RD_DATA = 32'hDEAD_BEEF;
`endif

    // Index of the read-only write counter
    localparam logic [9:0] CNT_IDX = 10'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_wait;
    logic [9:0]  r_idx;
    logic        r_write;
    logic        r_bad;
    logic [31:0] r_wdata;
    logic [31:0] r_prdata;
    logic        r_pready;
    logic        r_pslverr;
    logic [31:0] r_regs [NUM_REGS-1];
    logic [31:0] r_wr_cnt;

    logic        w_setup;
    logic        w_setup_bad;
    logic        w_do_write;
    logic [31:0] w_rd_data;
    logic [31:0] w_resp_data;
    logic        w_unused_addr;

    // Upper address bits are outside the decoded window
    assign w_unused_addr = ^PADDR[31:12];

    assign w_setup = PSEL && !PENABLE;

    // Out-of-range index, misaligned address, or write to the counter
    assign w_setup_bad = ({1'b0, PADDR[11:2]} >= 11'(NUM_REGS)) ||
                         (PADDR[1:0] != 2'b00) ||
                         (PWRITE && (PADDR[11:2] == CNT_IDX));

    // Commit happens on the edge that leaves DONE
    assign w_do_write = (r_state == ST_DONE) && r_write && !r_bad;

    // Read mux over the latched index; the counter is the fall-through value
    always_comb begin
        w_rd_data = r_wr_cnt;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            w_rd_data = (r_idx == 10'(i)) ? r_regs[i] : w_rd_data;
        end
    end

    // Response data: writes return 0, bad reads return the configured pattern
    assign w_resp_data = r_write ? 32'h0000_0000 :
                         (r_bad  ? BAD_RD_DATA : w_rd_data);

    // Transfer FSM with registered PREADY/PRDATA/PSLVERR
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= ST_IDLE;
            r_wait    <= 4'd0;
            r_idx     <= 10'd0;
            r_write   <= 1'b0;
            r_bad     <= 1'b0;
            r_wdata   <= 32'h0000_0000;
            r_prdata  <= 32'h0000_0000;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= 32'h0000_0000;
                    r_pslverr <= 1'b0;
                    // PSEL with PENABLE already high is not a setup phase
                    if (w_setup) begin
                        r_idx   <= PADDR[11:2];
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_bad   <= w_setup_bad;
                        r_wait  <= 4'(WAIT_STATES);
                        r_state <= ST_ACCESS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!(PSEL && PENABLE)) begin
                        // Master abandoned the transfer
                        r_state <= ST_IDLE;
                    end else if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end else begin
                        // Response is captured here so it is valid with PREADY
                        r_pready  <= 1'b1;
                        r_prdata  <= w_resp_data;
                        r_pslverr <= SLVERR_EN & r_bad;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= 32'h0000_0000;
                    r_pslverr <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= 32'h0000_0000;
                    r_pslverr <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Register bank and write-transfer counter
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_wr_cnt <= 32'h0000_0000;
        end else if (w_do_write) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (r_idx == 10'(i)) begin
                    r_regs[i] <= r_wdata;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
            r_wr_cnt <= r_wr_cnt + 32'd1;
        end else begin
            r_wr_cnt <= r_wr_cnt;
        end
    end

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_reg_slave
//
// Directed bench for apb_reg_slave. Three instances share one clock:
//   index 0 : WAIT_STATES=1, RESET_VAL=32'h600D_0000 (basic, bad access, reset)
//   index 1 : WAIT_STATES=0, RESET_VAL=0             (back-to-back writes)
//   index 2 : WAIT_STATES=3, RESET_VAL=32'h5A5A_0000 (abort, reset mid-transfer)
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. they show the value held during the current cycle.
// -----------------------------------------------------------------------------
module tb_apb_reg_slave;

    localparam logic [31:0] RV0 = 32'h600D_0000;
    localparam logic [31:0] RV2 = 32'h5A5A_0000;
`ifdef APB_REG_SLAVE_SLVERR_EN
    localparam logic        EXP_ERR    = 1'b1;
    localparam logic [31:0] EXP_BAD_RD = 32'h0000_0000;
`else
    localparam logic        EXP_ERR    = 1'b0;
    localparam logic [31:0] EXP_BAD_RD = 32'hDEAD_BEEF;
`endif

    logic        hclk = 1'b0;
    logic        hreset  [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int n_checks = 0;
    int n_err    = 0;
    int hi;

    always #5 hclk = ~hclk;

    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(1), .RESET_VAL(RV0)) u_ws1 (
        .HCLK(hclk), .HRESET(hreset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(0), .RESET_VAL(32'h0000_0000)) u_ws0 (
        .HCLK(hclk), .HRESET(hreset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(3), .RESET_VAL(RV2)) u_ws3 (
        .HCLK(hclk), .HRESET(hreset[2]), .PSEL(psel[2]), .PENABLE(penable[2]),
        .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete APB transfer; ends in the PREADY cycle with PSEL/PENABLE high
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_cyc, input string tag);
        int cyc;
        @(posedge hclk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wd;
        chk({tag, "_setup_rdy"}, 32'(pready[d]), 32'h0);
        cyc = 1;
        @(posedge hclk); #1;
        penable[d] = 1'b1;
        cyc = 2;
        while (pready[d] !== 1'b1 && cyc < 20) begin
            @(posedge hclk); #1;
            cyc++;
        end
        chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_err"}, 32'(pslverr[d]), 32'(exp_err));
        if (!wr) chk({tag, "_rd"}, prdata[d], exp_rd);
    endtask

    task automatic idle(input int d);
        @(posedge hclk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            hreset[i] = 1'b1; psel[i] = 1'b0; penable[i] = 1'b0;
            pwrite[i] = 1'b0; paddr[i] = 32'h0; pwdata[i] = 32'h0;
        end

        // Power-on reset: outputs low while reset is held
        repeat (2) begin
            @(posedge hclk); #1;
            chk("por_ready", 32'(pready[0]), 32'h0);
            chk("por_err",   32'(pslverr[0]), 32'h0);
            chk("por_rdata", prdata[0], 32'h0);
        end
        for (int i = 0; i < 3; i++) hreset[i] = 1'b0;

        // WAIT_STATES=1: basic write/read, total 4 cycles each
        xfer(0, 1'b1, 32'h0000_0004, 32'hA5A5_0001, 32'h0, 1'b0, 4, "w004");
        xfer(0, 1'b0, 32'h0000_0004, 32'h0, 32'hA5A5_0001, 1'b0, 4, "r004");
        xfer(0, 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0001, 1'b0, 4, "rcnt1");
        xfer(0, 1'b0, 32'h0000_0000, 32'h0, RV0, 1'b0, 4, "r000");
        xfer(0, 1'b0, 32'h1000_0004, 32'h0, 32'hA5A5_0001, 1'b0, 4, "rhigh");

        // Bad accesses
        xfer(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0, EXP_ERR, 4, "bw020");
        xfer(0, 1'b0, 32'h0000_0002, 32'h0, EXP_BAD_RD, EXP_ERR, 4, "br002");
        xfer(0, 1'b0, 32'h0000_0020, 32'h0, EXP_BAD_RD, EXP_ERR, 4, "br020");
        xfer(0, 1'b1, 32'h0000_001C, 32'h0000_0055, 32'h0, EXP_ERR, 4, "bwcnt");
        xfer(0, 1'b1, 32'h0000_0006, 32'h0000_0066, 32'h0, EXP_ERR, 4, "bw006");
        xfer(0, 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0001, 1'b0, 4, "rcnt_bad");
        xfer(0, 1'b0, 32'h0000_0004, 32'h0, 32'hA5A5_0001, 1'b0, 4, "r004_bad");
        xfer(0, 1'b0, 32'h0000_0000, 32'h0, RV0, 1'b0, 4, "r000_bad");
        idle(0);

        // Reset after writes restores RESET_VAL and clears the counter
        @(posedge hclk); #1;
        hreset[0] = 1'b1;
        repeat (2) begin
            @(posedge hclk); #1;
            chk("rst_ready", 32'(pready[0]), 32'h0);
            chk("rst_err",   32'(pslverr[0]), 32'h0);
            chk("rst_rdata", prdata[0], 32'h0);
        end
        hreset[0] = 1'b0;
        xfer(0, 1'b0, 32'h0000_0004, 32'h0, RV0, 1'b0, 4, "rst_r004");
        xfer(0, 1'b0, 32'h0000_001C, 32'h0, 32'h0, 1'b0, 4, "rst_rcnt");
        idle(0);

        // WAIT_STATES=0: back-to-back writes, 3 cycles each
        xfer(1, 1'b1, 32'h0000_0000, 32'h1111_0000, 32'h0, 1'b0, 3, "b2b_w000");
        xfer(1, 1'b1, 32'h0000_0008, 32'h2222_0000, 32'h0, 1'b0, 3, "b2b_w008");
        xfer(1, 1'b1, 32'h0000_0010, 32'h3333_0000, 32'h0, 1'b0, 3, "b2b_w010");
        xfer(1, 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0003, 1'b0, 3, "b2b_rcnt");
        xfer(1, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_0000, 1'b0, 3, "b2b_r000");
        xfer(1, 1'b0, 32'h0000_0008, 32'h0, 32'h2222_0000, 1'b0, 3, "b2b_r008");
        xfer(1, 1'b0, 32'h0000_0010, 32'h0, 32'h3333_0000, 1'b0, 3, "b2b_r010");
        idle(1);

        // WAIT_STATES=3: PENABLE dropped mid-wait aborts the write
        hi = 0;
        @(posedge hclk); #1;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h0000_000C; pwdata[2] = 32'h1234_5678;
        hi += int'(pready[2]);
        @(posedge hclk); #1; penable[2] = 1'b1; hi += int'(pready[2]);
        @(posedge hclk); #1; hi += int'(pready[2]);
        @(posedge hclk); #1; penable[2] = 1'b0; hi += int'(pready[2]);
        @(posedge hclk); #1; psel[2] = 1'b0; hi += int'(pready[2]);
        repeat (6) begin
            @(posedge hclk); #1;
            hi += int'(pready[2]);
        end
        chk("abort_no_ready", 32'(hi), 32'h0);
        xfer(2, 1'b0, 32'h0000_000C, 32'h0, RV2, 1'b0, 6, "abort_r00c");
        xfer(2, 1'b0, 32'h0000_001C, 32'h0, 32'h0, 1'b0, 6, "abort_rcnt");
        xfer(2, 1'b1, 32'h0000_000C, 32'h0000_00C3, 32'h0, 1'b0, 6, "abort_w00c");
        xfer(2, 1'b0, 32'h0000_000C, 32'h0, 32'h0000_00C3, 1'b0, 6, "post_r00c");
        xfer(2, 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0001, 1'b0, 6, "post_rcnt");
        idle(2);

        // Reset asserted during ACCESS of a write
        hi = 0;
        @(posedge hclk); #1;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h0000_0010; pwdata[2] = 32'h7777_7777;
        hi += int'(pready[2]);
        @(posedge hclk); #1; penable[2] = 1'b1; hi += int'(pready[2]);
        @(posedge hclk); #1; hreset[2] = 1'b1; hi += int'(pready[2]);
        repeat (2) begin
            @(posedge hclk); #1;
            hi += int'(pready[2]);
        end
        hreset[2] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
        repeat (6) begin
            @(posedge hclk); #1;
            hi += int'(pready[2]);
        end
        chk("rstmid_no_ready", 32'(hi), 32'h0);
        xfer(2, 1'b0, 32'h0000_0010, 32'h0, RV2, 1'b0, 6, "rstmid_r010");
        xfer(2, 1'b0, 32'h0000_001C, 32'h0, 32'h0, 1'b0, 6, "rstmid_rcnt");
        idle(2);

        repeat (2) @(posedge hclk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
